// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
        output alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
        input  alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM sequencing the multicycle MIPS datapath: fetch, decode, execute,
// memory and writeback for lw, sw, R-type, beq, addi and j.
module mips_multicycle_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master io_bus
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [2:0] w_funct_alu;

    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_iord;
    logic       w_memtoreg;
    logic       w_regdst;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [2:0] w_alucontrol;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (io_bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR, so anything but sw is a load.
            S_MEMADR:  w_next = (io_bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (io_bus.funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            default:   w_funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_regwrite   = 1'b0;
        w_iord       = 1'b0;
        w_memtoreg   = 1'b0;
        w_regdst     = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_pcsrc      = 2'b00;
        w_alucontrol = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_alusrcb = 2'b01;
            end
            S_DECODE:  w_alusrcb = 2'b11;
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD:   w_iord = 1'b1;
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                w_alusrca    = 1'b1;
                w_alucontrol = w_funct_alu;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca    = 1'b1;
                w_alucontrol = ALU_SUB;
                w_pcsrc      = 2'b01;
                w_branch     = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_ADDIWB:  w_regwrite = 1'b1;
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset already forces r_state to FETCH; only the write enables need masking.
    assign io_bus.pcen       = ~reset & (w_pcwrite | (w_branch & io_bus.zero));
    assign io_bus.irwrite    = ~reset & w_irwrite;
    assign io_bus.memwrite   = ~reset & w_memwrite;
    assign io_bus.regwrite   = ~reset & w_regwrite;
    assign io_bus.iord       = w_iord;
    assign io_bus.memtoreg   = w_memtoreg;
    assign io_bus.regdst     = w_regdst;
    assign io_bus.alusrca    = w_alusrca;
    assign io_bus.alusrcb    = w_alusrcb;
    assign io_bus.pcsrc      = w_pcsrc;
    assign io_bus.alucontrol = w_alucontrol;
    assign io_bus.state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table-driven latency/ALU sweep,
// randomized instruction stream against a path/output model, reset and corner sequences.
module tb_mips_multicycle_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [5:0] legal_ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    logic [5:0] functs    [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         lat;
        logic [2:0] alu;
        logic       br_pcen;
    } vec_t;

    vec_t vt[$];

    // Packed view: {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
    //               alusrcb, pcsrc, alucontrol, state}
    function automatic logic [18:0] actual();
        return {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord, bus.memtoreg,
                bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.state};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [18:0] model(input int st, input logic [5:0] f, input logic z);
        logic pw, br, ir, mw, rw, io, m2r, rd, a;
        logic [1:0] b, ps;
        logic [2:0] alu;
        logic [3:0] s4;
        pw = 0; br = 0; ir = 0; mw = 0; rw = 0; io = 0; m2r = 0; rd = 0; a = 0;
        b = 2'b00; ps = 2'b00; alu = 3'b010;
        s4 = st[3:0];
        case (st)
            0:  begin ir = 1; pw = 1; b = 2'b01; end
            1:  b = 2'b11;
            2:  begin a = 1; b = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin a = 1; alu = alu_of(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin a = 1; alu = 3'b110; ps = 2'b01; br = 1; end
            9:  begin a = 1; b = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        return {pw | (br & z), ir, mw, rw, io, m2r, rd, a, b, ps, alu, s4};
    endfunction

    function automatic logic [18:0] model_reset();
        logic [18:0] v;
        v = model(0, 6'b0, 1'b0);
        v[18:15] = 4'b0000;
        return v;
    endfunction

    // State sequence an instruction walks from FETCH up to (not including) the next FETCH.
    function automatic int path_of(input logic [5:0] op, output int seq [0:5]);
        for (int i = 0; i < 6; i++) seq[i] = 0;
        seq[1] = 1;
        case (op)
            OP_LW:   begin seq[2] = 2; seq[3] = 3; seq[4] = 4; return 5; end
            OP_SW:   begin seq[2] = 2; seq[3] = 5; return 4; end
            OP_R:    begin seq[2] = 6; seq[3] = 7; return 4; end
            OP_BEQ:  begin seq[2] = 8; return 3; end
            OP_ADDI: begin seq[2] = 9; seq[3] = 10; return 4; end
            OP_J:    begin seq[2] = 11; return 3; end
            default: return 2;
        endcase
    endfunction

    task automatic check(input string nm, input logic [18:0] got, input logic [18:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Entered just after a negedge with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
        int seq [0:5];
        int len;
        len = path_of(op, seq);
        bus.op = op; bus.funct = f; bus.zero = z;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("op=%b funct=%b step%0d", op, f, k), actual(), model(seq[k], f, z));
        end
        @(negedge clk);
        #1;
        check($sformatf("op=%b back to FETCH", op), actual(), model(0, f, z));
    endtask

    task automatic measure(input vec_t v);
        int n;
        logic [2:0] alu_seen;
        logic br_seen;
        bus.op = v.op; bus.funct = v.funct; bus.zero = v.zero;
        n = 0; alu_seen = 3'b010; br_seen = 1'b0;
        do begin
            @(negedge clk);
            #1;
            n++;
            if (bus.state == 4'd6) alu_seen = bus.alucontrol;
            if (bus.state == 4'd8) br_seen = bus.pcen;
        end while (bus.state != 4'd0 && n < 12);
        check_int({v.name, " latency"}, n, v.lat);
        check_int({v.name, " execute alucontrol"}, int'(alu_seen), int'(v.alu));
        check_int({v.name, " branch pcen"}, int'(br_seen), int'(v.br_pcen));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;

        vt.push_back('{"lw",       OP_LW,   6'b000000, 1'b0, 5, 3'b010, 1'b0});
        vt.push_back('{"sw",       OP_SW,   6'b000000, 1'b0, 4, 3'b010, 1'b0});
        vt.push_back('{"add",      OP_R,    6'b100000, 1'b0, 4, 3'b010, 1'b0});
        vt.push_back('{"sub",      OP_R,    6'b100010, 1'b1, 4, 3'b110, 1'b0});
        vt.push_back('{"and",      OP_R,    6'b100100, 1'b0, 4, 3'b000, 1'b0});
        vt.push_back('{"or",       OP_R,    6'b100101, 1'b0, 4, 3'b001, 1'b0});
        vt.push_back('{"slt",      OP_R,    6'b101010, 1'b0, 4, 3'b111, 1'b0});
        vt.push_back('{"funct0",   OP_R,    6'b000000, 1'b0, 4, 3'b010, 1'b0});
        vt.push_back('{"beq z=1",  OP_BEQ,  6'b000000, 1'b1, 3, 3'b010, 1'b1});
        vt.push_back('{"beq z=0",  OP_BEQ,  6'b000000, 1'b0, 3, 3'b010, 1'b0});
        vt.push_back('{"addi",     OP_ADDI, 6'b000000, 1'b0, 4, 3'b010, 1'b0});
        vt.push_back('{"j",        OP_J,    6'b000000, 1'b0, 3, 3'b010, 1'b0});
        vt.push_back('{"illegal",  6'h3f,   6'b000000, 1'b0, 2, 3'b010, 1'b0});

        // Power-on reset, asserted between clock edges: state must clear asynchronously.
        #2 reset = 1'b1;
        #1 check("reset async", actual(), model_reset());
        @(negedge clk); #1 check("reset held 1", actual(), model_reset());
        @(negedge clk);
        reset = 1'b0;
        #1 check("first FETCH after reset", actual(), model(0, 6'b0, 1'b0));

        foreach (vt[i]) measure(vt[i]);

        // Hand-written per-cycle walks of each instruction class.
        run_instr(OP_LW, 6'b0, 1'b0);
        run_instr(OP_SW, 6'b0, 1'b1);
        run_instr(OP_BEQ, 6'b0, 1'b1);
        run_instr(OP_BEQ, 6'b0, 1'b0);
        run_instr(OP_ADDI, 6'b0, 1'b0);
        run_instr(OP_J, 6'b0, 1'b0);
        run_instr(6'h3f, 6'b0, 1'b0);

        // Reset landing in ALUWB must kill the pending register write.
        bus.op = OP_R; bus.funct = 6'b100010; bus.zero = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1 check("in ALUWB before reset", actual(), model(7, 6'b100010, 1'b0));
        reset = 1'b1;
        #1 check("reset mid ALUWB", actual(), model_reset());
        @(negedge clk); #1 check("reset mid held 1", actual(), model_reset());
        @(negedge clk); #1 check("reset mid held 2", actual(), model_reset());
        reset = 1'b0;
        #1 check("FETCH after mid reset", actual(), model(0, 6'b100010, 1'b0));

        // Unused encoding: enables low, then back to FETCH.
        force dut.r_state = 4'd13;
        #1 check("state 13 outputs", actual(), model(13, 6'b100010, 1'b0));
        release dut.r_state;
        @(negedge clk);
        #1 check("state 13 -> FETCH", actual(), model(0, 6'b100010, 1'b0));

        // Randomized instruction stream.
        repeat (60) begin
            logic [5:0] op, f;
            logic z;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel < 6) op = legal_ops[sel];
            else op = 6'($urandom);
            if ($urandom_range(0, 3) != 0) f = functs[$urandom_range(0, 4)];
            else f = 6'($urandom);
            z = 1'($urandom);
            run_instr(op, f, z);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control unit for the multicycle MIPS datapath, issuing operation codes to the 32-bit ALU and consuming its `zero` flag. It is a Moore state machine sequencing fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, plus the 3-bit ALU function code. It supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag
- pcen  output  1  PC write enable
- irwrite  output  1  instruction register load
- memwrite  output  1  data memory write
- regwrite  output  1  register file write
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  output  1  writeback select: 0 = ALUOut, 1 = Data
- regdst  output  1  destination select: 0 = rt, 1 = rd
- alusrca  output  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU function: f[2] inverts B and sets carry-in; f[1:0] selects 00 and, 01 or, 10 sum, 11 slt
- state  output  4  current state encoding, for debug and verification

## Operation
- ALU codes: add = 010, sub = 110, and = 000, or = 001, slt = 111.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Functs: add 100000, sub 100010, and 100100, or 100101, slt 101010. Any other funct gives alucontrol 010.
- Outputs not listed for a state are 0; alucontrol is 010 unless listed.
- States (encoding = number):
  - 0 FETCH: irwrite=1, pcwrite=1, alusrcb=01. Next: DECODE.
  - 1 DECODE: alusrcb=11. Next by op: lw/sw → MEMADR; R → EXECUTE; beq → BRANCH; addi → ADDIEX; j → JUMP; any other op → FETCH (illegal opcode, no side effects).
  - 2 MEMADR: alusrca=1, alusrcb=10. Next: lw → MEMRD; sw → MEMWR.
  - 3 MEMRD: iord=1. Next: MEMWB.
  - 4 MEMWB: memtoreg=1, regwrite=1. Next: FETCH.
  - 5 MEMWR: iord=1, memwrite=1. Next: FETCH.
  - 6 EXECUTE: alusrca=1, alusrcb=00, alucontrol decoded from funct. Next: ALUWB.
  - 7 ALUWB: regdst=1, regwrite=1. Next: FETCH.
  - 8 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. Next: FETCH.
  - 9 ADDIEX: alusrca=1, alusrcb=10. Next: ADDIWB.
  - 10 ADDIWB: regwrite=1. Next: FETCH.
  - 11 JUMP: pcsrc=10, pcwrite=1. Next: FETCH.
- pcen = pcwrite | (branch & zero). This is the only output that depends combinationally on an input other than op/funct.
- Unused encodings 12–15 transition to FETCH with all enables 0.

## Timing
- State register updates on the rising edge of clk. Outputs are combinational from state (plus funct in EXECUTE, zero in BRANCH).
- op and funct are sampled only in DECODE/MEMADR/EXECUTE. The IR holds them stable because irwrite is asserted only in FETCH.
- Latency in cycles from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- While reset is high:
  - state = 0 and selects take FETCH values;
  - pcen, irwrite, memwrite and regwrite are forced 0.
- First FETCH enables assert in the first cycle after reset deasserts.
- Reset mid-instruction aborts immediately: no further memwrite/regwrite for that instruction.

## Test plan
- Reset: assert reset for 2 cycles during ALUWB → state=0 asynchronously, regwrite=0, pcen=0 while high; irwrite=1 and pcen=1 on the first cycle after release.
- lw (op 100011) → states 0,1,2,3,4,0. MEMRD has iord=1. MEMWB has memtoreg=1, regwrite=1, regdst=0. sw (op 101011) → 0,1,2,5,0 with memwrite=1 only in state 5.
- R-type sweep: funct 100000/100010/100100/100101/101010 → alucontrol in EXECUTE 010/110/000/001/111. ALUWB has regdst=1. funct 000000 → 010.
- beq (op 000100): with zero=1, pcen=1 in BRANCH with pcsrc=01 and alucontrol=110; with zero=0, pcen=0. Both return to FETCH after 3 cycles.
- addi → 0,1,9,10,0 with alusrcb=10 in state 9 and regwrite=1, regdst=0 in state 10. j → 0,1,11,0 with pcsrc=10, pcen=1 in state 11.
- Illegal op 111111 → 0,1,0 with no memwrite/regwrite asserted. Forced state 13 → next state 0.
